// File: rtl/ceespu_pc_ctrl_pkg.sv
// Shared defaults and types for the ceespu program-counter controller.
// Optional return-address stack is enabled with CEESPU_PC_RAS_EN.
package ceespu_pc_ctrl_pkg;

    localparam int unsigned PC_ADDR_W    = 14;
    localparam int unsigned PC_RESET_VEC = 0;
    localparam int unsigned PC_TRAP_VEC  = 4;
    localparam int unsigned PC_RAS_DEPTH = 4;

    typedef enum logic {
        NORMAL = 1'b0,
        TRAP   = 1'b1
    } pc_state_t;

endpackage

// File: rtl/ceespu_pc_ctrl_if.sv
// Redirect/request bundle between decode/branch unit and the PC controller.
interface ceespu_pc_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              i_stall;
    logic              i_branch;
    logic [ADDR_W-1:0] i_branchAddress;
    logic              i_call;
    logic              i_ret;
    logic              i_trap;
    logic              i_reti;
    logic [ADDR_W-1:0] o_PC;
    logic [ADDR_W-1:0] o_epc;
    logic              o_inTrap;
    logic              o_rasMiss;

    modport master (
        output i_stall, i_branch, i_branchAddress, i_call, i_ret, i_trap, i_reti,
        input  o_PC, o_epc, o_inTrap, o_rasMiss
    );

    modport slave (
        input  i_stall, i_branch, i_branchAddress, i_call, i_ret, i_trap, i_reti,
        output o_PC, o_epc, o_inTrap, o_rasMiss
    );
endinterface

// File: rtl/ceespu_pc_ctrl_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Push and pop together replace the top entry in place.
module ceespu_pc_ctrl_ras #(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_empty,
    output logic         o_full
);
    localparam int CW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_ptr;
    logic [CW:0]   r_count;
    logic          w_replace;
    logic          w_grow;
    logic [CW-1:0] w_wrIdx;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (CW+1)'(DEPTH));
    assign o_top     = r_mem[r_ptr];
    // Pop on an empty stack has nothing to replace, so a paired push grows instead.
    assign w_replace = i_push && i_pop && !o_empty;
    assign w_grow    = i_push && !w_replace;
    assign w_wrIdx   = w_replace ? r_ptr : r_ptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_grow) begin
            r_ptr <= r_ptr + 1'b1;
            if (!o_full)
                r_count <= r_count + 1'b1;
        end else if (i_pop && !i_push && !o_empty) begin
            r_ptr   <= r_ptr - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push)
            r_mem[w_wrIdx] <= i_data;
    end
endmodule

// File: rtl/ceespu_pc_ctrl.sv
// Fetch-stage PC controller: sequential advance, branch, trap/reti FSM with EPC.
// Define CEESPU_PC_RAS_EN to add call/return prediction through a return-address stack.
module ceespu_pc_ctrl
    import ceespu_pc_ctrl_pkg::*;
#(
    parameter int              ADDR_W    = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(PC_TRAP_VEC),
    parameter int              RAS_DEPTH = PC_RAS_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    ceespu_pc_ctrl_if.slave  bus
);
    pc_state_t         r_state, w_stateNext;
    logic [ADDR_W-1:0] r_pc, r_epc;
    logic              r_rasMiss;
    logic [ADDR_W-1:0] w_npcBase, w_pcNext, w_epcNext;
    logic              w_takeTrap, w_takeReti;
    logic              w_push, w_pop, w_miss;
    logic [ADDR_W-1:0] w_rasTop;

    assign w_npcBase  = bus.i_stall ? r_pc : r_pc + 1'b1;
    assign w_takeTrap = bus.i_trap && (r_state == NORMAL);
    assign w_takeReti = bus.i_reti && (r_state == TRAP);

`ifdef CEESPU_PC_RAS_EN
    logic w_rasEmpty, w_rasFull, w_retReq;

    // Call/return only act when no higher-priority redirect claims the cycle.
    assign w_push   = !w_takeTrap && !w_takeReti && bus.i_branch && bus.i_call;
    assign w_retReq = !w_takeTrap && !w_takeReti && !bus.i_branch && bus.i_ret;
    assign w_pop    = w_retReq && !w_rasEmpty;
    assign w_miss   = w_retReq && w_rasEmpty;

    ceespu_pc_ctrl_ras #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_pc + 1'b1),
        .o_top   (w_rasTop),
        .o_empty (w_rasEmpty),
        .o_full  (w_rasFull)
    );

    logic w_unused;
    assign w_unused = &{1'b0, w_rasFull};
`else
    assign w_push   = 1'b0;
    assign w_pop    = 1'b0;
    assign w_miss   = 1'b0;
    assign w_rasTop = '0;

    logic w_unused;
    assign w_unused = &{1'b0, bus.i_call, bus.i_ret, w_push, RAS_DEPTH[0]};
`endif

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= NORMAL;
        else       r_state <= w_stateNext;
    end

    // FSM: next state
    always_comb begin
        w_stateNext = r_state;
        if (w_takeTrap)      w_stateNext = TRAP;
        else if (w_takeReti) w_stateNext = NORMAL;
    end

    // FSM: outputs
    always_comb begin
        bus.o_inTrap = (r_state == TRAP);
    end

    always_comb begin
        w_pcNext  = w_npcBase;
        w_epcNext = r_epc;
        if (w_takeTrap) begin
            w_pcNext  = TRAP_VEC;
            w_epcNext = w_npcBase;
        end else if (w_takeReti) begin
            w_pcNext = r_epc;
        end else if (bus.i_branch) begin
            w_pcNext = bus.i_branchAddress;
        end else if (w_pop) begin
            w_pcNext = w_rasTop;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc      <= RESET_VEC;
            r_epc     <= '0;
            r_rasMiss <= 1'b0;
        end else begin
            r_pc      <= w_pcNext;
            r_epc     <= w_epcNext;
            r_rasMiss <= w_miss;
        end
    end

    assign bus.o_PC      = r_pc;
    assign bus.o_epc     = r_epc;
    assign bus.o_rasMiss = r_rasMiss;
endmodule

// File: tb/tb_ceespu_pc_ctrl.sv
// Directed scoreboard bench for ceespu_pc_ctrl: a default-width DUT (RAS_DEPTH=2)
// and a 4-bit DUT for wrap-around.
module tb_ceespu_pc_ctrl;

    logic clk = 1'b0;
    logic rstA, rstB;
    always #5 clk = ~clk;

    ceespu_pc_ctrl_if #(.ADDR_W(14)) busA ();
    ceespu_pc_ctrl_if #(.ADDR_W(4))  busB ();

    ceespu_pc_ctrl #(.ADDR_W(14), .RAS_DEPTH(2)) dutA (
        .i_clk (clk),
        .i_rst (rstA),
        .bus   (busA.slave)
    );

    ceespu_pc_ctrl #(.ADDR_W(4), .RAS_DEPTH(4)) dutB (
        .i_clk (clk),
        .i_rst (rstB),
        .bus   (busB.slave)
    );

    typedef struct {
        logic [13:0] pc;
        logic [13:0] epc;
        logic        it;
        logic        miss;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input string fld, input logic [13:0] obs, input logic [13:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
        end
    endtask

    task automatic compare(input logic [13:0] pc, input logic [13:0] epc, input logic it, input logic miss);
        exp_t e;
        n_tests++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, "pc",      pc,           e.pc);
            chk(e.tag, "epc",     epc,          e.epc);
            chk(e.tag, "inTrap",  14'(it),      14'(e.it));
            chk(e.tag, "rasMiss", 14'(miss),    14'(e.miss));
        end
    endtask

    // inp = {rst, stall, branch, call, ret, trap, reti}
    task automatic stepA(input logic [6:0] inp, input logic [13:0] addr,
                         input logic [13:0] pc, input logic [13:0] epc,
                         input logic it, input logic miss, input string tag);
        exp_t e;
        {rstA, busA.i_stall, busA.i_branch, busA.i_call, busA.i_ret, busA.i_trap, busA.i_reti} = inp;
        busA.i_branchAddress = addr;
        e.pc = pc; e.epc = epc; e.it = it; e.miss = miss; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(busA.o_PC, busA.o_epc, busA.o_inTrap, busA.o_rasMiss);
    endtask

    task automatic stepB(input logic [6:0] inp, input logic [3:0] addr,
                         input logic [3:0] pc, input logic [3:0] epc,
                         input logic it, input string tag);
        exp_t e;
        {rstB, busB.i_stall, busB.i_branch, busB.i_call, busB.i_ret, busB.i_trap, busB.i_reti} = inp;
        busB.i_branchAddress = addr;
        e.pc = 14'(pc); e.epc = 14'(epc); e.it = it; e.miss = 1'b0; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(14'(busB.o_PC), 14'(busB.o_epc), busB.o_inTrap, busB.o_rasMiss);
    endtask

    localparam logic [6:0] RST  = 7'b1000000;
    localparam logic [6:0] FREE = 7'b0000000;
    localparam logic [6:0] STL  = 7'b0100000;
    localparam logic [6:0] BR   = 7'b0010000;
    localparam logic [6:0] CALL = 7'b0011000;
    localparam logic [6:0] RET  = 7'b0000100;
    localparam logic [6:0] TRP  = 7'b0000010;
    localparam logic [6:0] RETI = 7'b0000001;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstA = 1'b1; rstB = 1'b1;
        {busA.i_stall, busA.i_branch, busA.i_call, busA.i_ret, busA.i_trap, busA.i_reti} = '0;
        {busB.i_stall, busB.i_branch, busB.i_call, busB.i_ret, busB.i_trap, busB.i_reti} = '0;
        busA.i_branchAddress = '0;
        busB.i_branchAddress = '0;
        #1;

        // reset, free run, stall
        stepA(RST,  0, 0, 0, 0, 0, "reset");
        stepA(FREE, 0, 1, 0, 0, 0, "seq1");
        stepA(FREE, 0, 2, 0, 0, 0, "seq2");
        stepA(FREE, 0, 3, 0, 0, 0, "seq3");
        stepA(STL,  0, 3, 0, 0, 0, "stall1");
        stepA(STL,  0, 3, 0, 0, 0, "stall2");
        stepA(STL | BR, 9, 9, 0, 0, 0, "br_over_stall");

        // trap / reti
        stepA(BR,   6, 6, 0, 0, 0, "br6");
        stepA(FREE, 0, 7, 0, 0, 0, "seq7");
        stepA(TRP,  0, 4, 8, 1, 0, "trap");
        stepA(TRP,  0, 5, 8, 1, 0, "trap_ignored");
        stepA(RETI, 0, 8, 8, 0, 0, "reti");
        stepA(RETI, 0, 9, 8, 0, 0, "reti_ignored");

        // trap beats branch, reset mid-trap
        stepA(BR,   5, 5, 8, 0, 0, "br5");
        stepA(TRP | BR, 50, 4, 6, 1, 0, "trap_over_br");
        stepA(FREE, 0, 5, 6, 1, 0, "seq_in_trap");
        stepA(RST,  0, 0, 0, 0, 0, "rst_in_trap");
        stepA(FREE, 0, 1, 0, 0, 0, "seq_after_rst");
        stepA(STL | TRP, 0, 4, 1, 1, 0, "trap_stalled_epc");
        stepA(RETI, 0, 1, 1, 0, 0, "reti_stalled");

`ifdef CEESPU_PC_RAS_EN
        stepA(BR,   3,  3,  1, 0, 0, "br3");
        stepA(CALL, 20, 20, 1, 0, 0, "call20");
        stepA(FREE, 0,  21, 1, 0, 0, "seq21");
        stepA(CALL, 40, 40, 1, 0, 0, "call40");
        stepA(RET,  0,  22, 1, 0, 0, "ret22");
        stepA(RET,  0,  4,  1, 0, 0, "ret4");
        stepA(RET,  0,  5,  1, 0, 1, "ret_miss");
        stepA(FREE, 0,  6,  1, 0, 0, "miss_clear");
        // depth 2: oldest return address is overwritten
        stepA(BR,   10, 10, 1, 0, 0, "br10");
        stepA(CALL, 100, 100, 1, 0, 0, "callA");
        stepA(BR,   20, 20, 1, 0, 0, "br20");
        stepA(CALL, 200, 200, 1, 0, 0, "callB");
        stepA(BR,   30, 30, 1, 0, 0, "br30");
        stepA(CALL, 300, 300, 1, 0, 0, "callC");
        stepA(RET,  0,  31, 1, 0, 0, "ret31");
        stepA(RET,  0,  21, 1, 0, 0, "ret21");
        stepA(RET,  0,  22, 1, 0, 1, "ret_wrap_miss");
        stepA(7'b0001000, 0, 23, 1, 0, 0, "call_no_branch");
        stepA(RET,  0,  24, 1, 0, 1, "call_not_pushed");
        stepA(CALL | RET, 60, 60, 1, 0, 0, "call_ret_branch_wins");
        stepA(RET,  0,  61, 1, 0, 0, "ret_after_call_ret");
`else
        stepA(BR,   3,  3,  1, 0, 0, "br3");
        stepA(CALL, 20, 20, 1, 0, 0, "call_as_branch");
        stepA(RET,  0,  21, 1, 0, 0, "ret_ignored");
        stepA(STL | RET, 0, 21, 1, 0, 0, "ret_ignored_stall");
`endif

        // 4-bit wrap-around
        stepB(RST,  0,  0,  0, 0, "B_reset");
        stepB(BR,   15, 15, 0, 0, "B_br15");
        stepB(FREE, 0,  0,  0, 0, "B_wrap");
        stepB(BR,   15, 15, 0, 0, "B_br15b");
        stepB(TRP,  0,  4,  0, 1, "B_trap_epc_wrap");
        stepB(RETI, 0,  0,  0, 0, "B_reti");
        stepB(STL | BR, 9, 9, 0, 0, "B_br_over_stall");

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
